// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data widths, the NOP encoding and the fetch FSM state type.
package cpu_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_HALT = 2'd3
   } fetch_state_e;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control inputs, instruction-memory port and the IF/ID outputs.
interface fetch_stage_if;

   logic                      start;
   logic                      stall;
   logic                      branch_taken;
   logic [cpu_pkg::XLEN-1:0]  branch_target;
   logic [cpu_pkg::ILEN-1:0]  imem_instr;
   logic [cpu_pkg::XLEN-1:0]  imem_addr;
   logic                      imem_load;
   logic [cpu_pkg::ILEN-1:0]  if_id_instr;
   logic [cpu_pkg::XLEN-1:0]  if_id_pc4;
   logic                      if_id_valid;
   logic                      running;
   logic                      halted;

   // master: the fetch stage itself
   modport master (
      input  start, stall, branch_taken, branch_target, imem_instr,
      output imem_addr, imem_load, if_id_instr, if_id_pc4, if_id_valid, running, halted
   );

   // slave: hazard unit, ID stage and instruction memory side
   modport slave (
      output start, stall, branch_taken, branch_target, imem_instr,
      input  imem_addr, imem_load, if_id_instr, if_id_pc4, if_id_valid, running, halted
   );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; flush inserts a bubble and wins over enable.
module if_id_reg
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            flush,
   input  logic [ILEN-1:0] in_instr,
   input  logic [XLEN-1:0] in_pc4,
   output logic [ILEN-1:0] instr,
   output logic [XLEN-1:0] pc4,
   output logic            valid
);

   logic [ILEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] pc4_q, pc4_d;
   logic            valid_q, valid_d;

   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (flush) begin
         instr_d = NOP_INSTR;
         pc4_d   = '0;
         valid_d = 1'b0;
      end else if (en) begin
         instr_d = in_instr;
         pc4_d   = in_pc4;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= NOP_INSTR;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign instr = instr_q;
   assign pc4   = pc4_q;
   assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, load/run/halt FSM and IF/ID register.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | after reset, waiting for start; IF/ID held as bubble
//   LOAD    | one-cycle imem initialisation strobe, PC set to RESET_PC
//   RUN     | one fetch per cycle (branch > stall > end-of-program > fetch)
//   HALT    | program ended; PC frozen, branches ignored, start reloads
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0,
   parameter int unsigned     PROG_BYTES = 60
)
(
   input  logic          clk,
   input  logic          rst_n,
   fetch_stage_if.master bus
);

   localparam logic [XLEN-1:0] PROG_LIMIT = XLEN'(PROG_BYTES);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            load_q, load_d;
   logic            running_q, running_d;
   logic            halted_q, halted_d;
   logic            ifid_en;
   logic            ifid_flush;
   logic [XLEN-1:0] pc_plus4;

   assign pc_plus4 = pc_q + XLEN'(4);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            ifid_flush = 1'b1;
            if (bus.start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            ifid_flush = 1'b1;
            pc_d       = RESET_PC;
            state_d    = ST_RUN;
         end
         ST_RUN: begin
            if (bus.branch_taken) begin
               // the flush must happen even under stall, or the wrong-path word survives
               pc_d       = align_word(bus.branch_target);
               ifid_flush = 1'b1;
            end else if (bus.stall) begin
               pc_d = pc_q;
            end else if (pc_q >= PROG_LIMIT) begin
               ifid_flush = 1'b1;
               state_d    = ST_HALT;
            end else begin
               ifid_en = 1'b1;
               pc_d    = pc_plus4;
            end
         end
         ST_HALT: begin
            ifid_flush = 1'b1;
            if (bus.start) state_d = ST_LOAD;
         end
         default: begin
            ifid_flush = 1'b1;
            state_d    = ST_IDLE;
         end
      endcase
      load_d    = (state_d == ST_LOAD);
      running_d = (state_d == ST_RUN);
      halted_d  = (state_d == ST_HALT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         load_q    <= 1'b0;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         load_q    <= load_d;
         running_q <= running_d;
         halted_q  <= halted_d;
      end
   end

   if_id_reg u_if_id_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (ifid_en),
      .flush    (ifid_flush),
      .in_instr (bus.imem_instr),
      .in_pc4   (pc_plus4),
      .instr    (bus.if_id_instr),
      .pc4      (bus.if_id_pc4),
      .valid    (bus.if_id_valid)
   );

   assign bus.imem_addr = pc_q;
   assign bus.imem_load = load_q;
   assign bus.running   = running_q;
   assign bus.halted    = halted_q;

endmodule
